// File: rtl/mmio_uart_tx_if.sv
// CPU-side memory-mapped bus into the UART transmitter: word address,
// read/write strobes, write data and the OR-mergeable read data.
interface mmio_uart_tx_if;
    logic [15:0] memAddr;
    logic        memRe;
    logic        memWe;
    logic [15:0] memWBus;
    logic [15:0] memRBus;

    modport master (
        output memAddr,
        output memRe,
        output memWe,
        output memWBus,
        input  memRBus
    );

    modport slave (
        input  memAddr,
        input  memRe,
        input  memWe,
        input  memWBus,
        output memRBus
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIVISOR register window,
// 4-entry byte FIFO and a START/DATA/STOP serialiser clocked by a bit divisor.
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic              clk,
    input  logic              rst,
    mmio_uart_tx_if.slave     bus,
    output logic              tx,
    output logic              txIdle
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    state_t      state_q, state_d;
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [15:0] div_q, div_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic        sel;
    logic [1:0]  offset;
    logic        wr_en;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        busy;
    logic        bit_done;
    logic [15:0] status_word;

    // Address decode and status flags
    always_comb begin
        sel        = (bus.memAddr[15:2] == BASE_ADDR[15:2]);
        offset     = bus.memAddr[1:0];
        wr_en      = bus.memWe && sel;
        push_req   = wr_en && (offset == OFF_DATA);
        fifo_empty = (count_q == 3'd0);
        fifo_full  = (count_q == 3'd4);
        busy       = (state_q != IDLE);
        bit_done   = (bit_cnt_q == 16'd0);
        status_word = {9'b0, count_q, overflow_q, fifo_empty, fifo_full, busy};
    end

    // Serialiser: each bit lasts bit_cnt reload + 1 clocks
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_cnt_d = div_q;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_cnt_d = div_q;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = div_q;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame so queued bytes leave with no idle gap
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_mem[rd_ptr_q];
                        bit_cnt_d = div_q;
                        state_d   = START;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping and register writes
    always_comb begin
        push_ok    = push_req && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q + {1'b0, push_ok};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        count_d    = count_q + {2'b0, push_ok} - {2'b0, pop};
        overflow_d = overflow_q;
        div_d      = div_q;
        if (wr_en && (offset == OFF_STATUS) && bus.memWBus[3]) begin
            overflow_d = 1'b0;
        end
        // A dropped byte wins over a simultaneous clear so it is never lost silently
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (wr_en && (offset == OFF_DIVISOR)) begin
            div_d = bus.memWBus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
            bit_cnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Payload storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= bus.memWBus[7:0];
        end
    end

    always_comb begin
        bus.memRBus = 16'h0000;
        if (bus.memRe && sel) begin
            case (offset)
                OFF_STATUS:  bus.memRBus = status_word;
                OFF_DIVISOR: bus.memRBus = div_q;
                default:     bus.memRBus = 16'h0000;
            endcase
        end
    end

    assign tx     = tx_q;
    assign txIdle = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: bytes written to DATA are queued as
// expected frames; a line monitor decodes tx and pops/compares each frame.
module tb_mmio_uart_tx;

    localparam logic [15:0] BASE = 16'hFF00;

    logic clk;
    logic rst;
    logic tx;
    logic txIdle;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .DEFAULT_DIV (16'd4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .tx     (tx),
        .txIdle (txIdle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q [$];
    int         starts [$];
    int         last_start = 0;
    int         mon_div = 4;
    int         mon_pos = 0;
    bit         mon_active = 1'b0;
    logic [9:0] mon_bits;
    int         n_frames = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Line monitor: samples the middle of every bit at the current divisor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_pos    = 0;
                    last_start = cyc;
                    starts.push_back(cyc);
                end else if (mon_active) begin
                    mon_pos++;
                end
                if (mon_active) begin
                    if (mon_pos >= mon_div / 2 && ((mon_pos - mon_div / 2) % (mon_div + 1)) == 0) begin
                        int k;
                        k = (mon_pos - mon_div / 2) / (mon_div + 1);
                        if (k <= 9) mon_bits[k] = tx;
                        if (k == 9) begin
                            logic [7:0] exp_b;
                            n_frames++;
                            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                            exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                            $display("frame %0d at cycle %0d: byte %h (expected %h)",
                                     n_frames, last_start, mon_bits[8:1], exp_b);
                            check("frame_start_bit", 32'(mon_bits[0]), 32'd0);
                            check("frame_byte", 32'(mon_bits[8:1]), 32'(exp_b));
                            check("frame_stop_bit", 32'(mon_bits[9]), 32'd1);
                        end
                    end
                    if (mon_pos == 10 * (mon_div + 1) - 1) mon_active = 1'b0;
                end
            end
        end
    end

    task automatic read_now(input logic [15:0] addr, output logic [15:0] data);
        bus_if.memAddr = addr;
        bus_if.memRe   = 1'b1;
        #1;
        data = bus_if.memRBus;
        bus_if.memRe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        read_now(addr, data);
    endtask

    task automatic drive_write(input logic [15:0] addr, input logic [15:0] data);
        bus_if.memAddr = addr;
        bus_if.memWBus = data;
        bus_if.memWe   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.memWe = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        drive_write(addr, data);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        bus_write(BASE, {8'h00, b});
        if (accepted) exp_q.push_back(b);
    endtask

    task automatic wait_idle(input int budget, output int at);
        int n = 0;
        @(negedge clk);
        while (!txIdle && n < budget) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check("idle_reached", 32'(txIdle), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        @(negedge clk);
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_cycle", 32'(cyc), 32'(target));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] rd;
    int          idle_at;
    int          s0;

    initial begin
        rst = 1'b1;
        bus_if.memAddr = 16'h0000;
        bus_if.memRe   = 1'b0;
        bus_if.memWe   = 1'b0;
        bus_if.memWBus = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state, readable while reset is held
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_txidle", 32'(txIdle), 32'd1);
        read_now(BASE + 16'd1, rd);
        check("rst_status", 32'(rd), 32'h0004);
        read_now(BASE + 16'd2, rd);
        check("rst_divisor", 32'(rd), 32'h0004);
        @(negedge clk);
        rst = 1'b0;

        // Single byte at DIVISOR=4
        mon_div = 4;
        push_byte(8'hA5, 1'b1);
        check("tx_before_fall", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        check("tx_fall_next_cycle", 32'(tx), 32'd0);
        wait_idle(200, idle_at);
        check("single_frame_len", 32'(idle_at - last_start), 32'd50);

        // Three back-to-back bytes: contiguous frames
        starts.delete();
        push_byte(8'h3C, 1'b1);
        push_byte(8'h81, 1'b1);
        push_byte(8'h7E, 1'b1);
        bus_read(BASE + 16'd1, rd);
        check("b2b_status_after_burst", 32'(rd), 32'h0021);
        s0 = last_start;
        wait_cyc(s0 + 50);
        read_now(BASE + 16'd1, rd);
        check("b2b_status_after_pop", 32'(rd), 32'h0011);
        wait_idle(400, idle_at);
        check("b2b_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check("b2b_gap_1", 32'(starts[1] - starts[0]), 32'd50);
            check("b2b_gap_2", 32'(starts[2] - starts[1]), 32'd50);
        end
        check("b2b_total_len", 32'(idle_at - s0), 32'd150);

        // Overflow while busy, clear, then full push coinciding with a pop
        push_byte(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        push_byte(8'hB0, 1'b1);
        push_byte(8'hB1, 1'b1);
        push_byte(8'hB2, 1'b1);
        push_byte(8'hB3, 1'b1);
        push_byte(8'hB4, 1'b0);
        push_byte(8'hB5, 1'b0);
        bus_read(BASE + 16'd1, rd);
        check("ovf_status_set", 32'(rd), 32'h004B);
        bus_write(BASE + 16'd1, 16'h0008);
        bus_read(BASE + 16'd1, rd);
        check("ovf_status_cleared", 32'(rd), 32'h0043);
        s0 = last_start;
        wait_cyc(s0 + 49);
        drive_write(BASE, 16'h00C7);
        exp_q.push_back(8'hC7);
        bus_read(BASE + 16'd1, rd);
        check("full_push_pop_status", 32'(rd), 32'h0043);
        wait_idle(600, idle_at);
        check("ovf_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of data bit 3
        bus_write(BASE + 16'd2, 16'd6);
        mon_div = 6;
        push_byte(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        s0 = last_start;
        wait_cyc(s0 + 30);
        check("pre_rst_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_txidle", 32'(txIdle), 32'd1);
        read_now(BASE + 16'd1, rd);
        check("midrst_status", 32'(rd), 32'h0004);
        read_now(BASE + 16'd2, rd);
        check("midrst_divisor", 32'(rd), 32'h0004);
        @(negedge clk);
        rst = 1'b0;
        mon_div = 4;

        // Decode: out-of-window accesses have no effect
        bus_read(BASE + 16'd4, rd);
        check("decode_rd_above", 32'(rd), 32'h0000);
        bus_read(BASE - 16'd1, rd);
        check("decode_rd_below", 32'(rd), 32'h0000);
        bus_write(BASE + 16'd4, 16'h0055);
        bus_write(BASE + 16'd6, 16'h0003);
        bus_write(BASE - 16'd1, 16'h0008);
        repeat (3) @(negedge clk);
        check("decode_tx_quiet", 32'(tx), 32'd1);
        bus_read(BASE + 16'd1, rd);
        check("decode_status", 32'(rd), 32'h0004);
        bus_read(BASE + 16'd2, rd);
        check("decode_divisor", 32'(rd), 32'h0004);
        bus_write(BASE + 16'd3, 16'hFFFF);
        bus_read(BASE + 16'd3, rd);
        check("reserved_read", 32'(rd), 32'h0000);
        bus_read(BASE, rd);
        check("data_read", 32'(rd), 32'h0000);

        // Read and write together return the pre-write divisor
        @(negedge clk);
        bus_if.memAddr = BASE + 16'd2;
        bus_if.memWBus = 16'h0000;
        bus_if.memWe   = 1'b1;
        bus_if.memRe   = 1'b1;
        #1;
        check("rw_same_cycle", 32'(bus_if.memRBus), 32'h0004);
        @(posedge clk);
        #1;
        bus_if.memWe = 1'b0;
        bus_if.memRe = 1'b0;
        bus_read(BASE + 16'd2, rd);
        check("divisor_zero", 32'(rd), 32'h0000);

        // DIVISOR=0: one clock per bit
        mon_div = 0;
        push_byte(8'h96, 1'b1);
        wait_idle(100, idle_at);
        check("div0_frame_len", 32'(idle_at - last_start), 32'd10);
        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
